// File: rtl/sum_uart_ctrl.sv
// Sum/latch/UART sequencer: debounced save buttons latch two operands, their sum goes to the UART.
// Build option ASCII_HEX_EN: send the sum as two ASCII hex digits plus LF instead of one raw byte.
`timescale 1ns/1ps
module sum_uart_ctrl #(
  parameter int BITS     = 3,
  parameter int DEBOUNCE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            save_a_n,
  input  logic            save_b_n,
  input  logic [BITS-1:0] data_in,
  input  logic            tx_busy,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  output logic [BITS-1:0] reg_a,
  output logic [BITS-1:0] reg_b,
  output logic [BITS:0]   sum,
  output logic            valid_a,
  output logic            valid_b,
  output logic            ctrl_busy
);

  // state     | meaning
  // S_IDLE    | latching operands, waiting for both
  // S_CALC    | register sum, load first character
  // S_SEND    | pulse tx_start once the UART is free
  // S_WAIT_HI | waiting for the UART to report busy
  // S_WAIT_LO | waiting for the frame to finish
  typedef enum logic [2:0] {S_IDLE, S_CALC, S_SEND, S_WAIT_HI, S_WAIT_LO} state_t;

  localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
`ifdef ASCII_HEX_EN
  localparam logic [1:0] LAST_IDX = 2'd2;
`else
  localparam logic [1:0] LAST_IDX = 2'd0;
`endif

  state_t          state_q, state_d;
  logic [1:0]      sa_q, sb_q;
  logic [BITS-1:0] d1_q, d2_q;
  logic [1:0]      acc_q, acc_d;
  logic [CW-1:0]   cnt_q [2];
  logic [CW-1:0]   cnt_d [2];
  logic [1:0]      lvl, press;
  logic [BITS-1:0] reg_a_q, reg_a_d, reg_b_q, reg_b_d;
  logic [BITS:0]   sum_q, sum_d;
  logic            va_q, va_d, vb_q, vb_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [1:0]      idx_q, idx_d;

  function automatic logic [7:0] char_of(input logic [BITS:0] s, input logic [1:0] idx);
    logic [7:0] s8;
    s8 = 8'(s);
`ifdef ASCII_HEX_EN
    begin
      logic [3:0] nib;
      nib = (idx == 2'd0) ? s8[7:4] : s8[3:0];
      if (idx == 2'd2)       char_of = 8'h0A;
      else if (nib < 4'd10)  char_of = 8'h30 + {4'h0, nib};
      else                   char_of = 8'h37 + {4'h0, nib};
    end
`else
    char_of = (idx == 2'd0) ? s8 : 8'h00;
`endif
  endfunction

  assign lvl = {sb_q[1], sa_q[1]};

  // A press is the accepted level flipping from released to pressed.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      acc_d[i] = acc_q[i];
      press[i] = 1'b0;
      if (lvl[i] != acc_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          acc_d[i] = lvl[i];
          press[i] = acc_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    reg_a_d   = reg_a_q;
    reg_b_d   = reg_b_q;
    sum_d     = sum_q;
    va_d      = va_q;
    vb_d      = vb_q;
    tx_data_d = tx_data_q;
    idx_d     = idx_q;
    tx_start  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press[0]) begin
          reg_a_d = d2_q;
          va_d    = 1'b1;
        end
        if (press[1]) begin
          reg_b_d = d2_q;
          vb_d    = 1'b1;
        end
        if (va_q && vb_q) state_d = S_CALC;
      end
      S_CALC: begin
        sum_d     = {1'b0, reg_a_q} + {1'b0, reg_b_q};
        tx_data_d = char_of(sum_d, 2'd0);
        idx_d     = 2'd0;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (tx_busy) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q != LAST_IDX) begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = char_of(sum_q, idx_q + 2'd1);
            state_d   = S_SEND;
          end else begin
            va_d    = 1'b0;
            vb_d    = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sa_q      <= 2'b11;
      sb_q      <= 2'b11;
      d1_q      <= '0;
      d2_q      <= '0;
      acc_q     <= 2'b11;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      reg_a_q   <= '0;
      reg_b_q   <= '0;
      sum_q     <= '0;
      va_q      <= 1'b0;
      vb_q      <= 1'b0;
      tx_data_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      sa_q      <= {sa_q[0], save_a_n};
      sb_q      <= {sb_q[0], save_b_n};
      d1_q      <= data_in;
      d2_q      <= d1_q;
      acc_q     <= acc_d;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
      reg_a_q   <= reg_a_d;
      reg_b_q   <= reg_b_d;
      sum_q     <= sum_d;
      va_q      <= va_d;
      vb_q      <= vb_d;
      tx_data_q <= tx_data_d;
      idx_q     <= idx_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign reg_a     = reg_a_q;
  assign reg_b     = reg_b_q;
  assign sum       = sum_q;
  assign valid_a   = va_q;
  assign valid_b   = vb_q;
  assign ctrl_busy = (state_q != S_IDLE);

endmodule

// File: doc/sum_uart_ctrl.md
Name: sum_uart_ctrl

Overview:
Sequencing controller for the sum/latch/UART datapath. Debounces the two active-low save buttons and latches operand A and operand B from the shared data input. Once both operands are held, it forms their sum and drives the UART transmitter through a start/busy handshake. It sits between the chip-level pin wrapper and the UART TX instance.

Parameters:
BITS, 3, operand width; sum width is BITS+1; legal range 1..7
DEBOUNCE, 4, consecutive stable cycles needed to accept a press or release; minimum 1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
save_a_n  input  1  button, active low: latch operand A
save_b_n  input  1  button, active low: latch operand B
data_in  input  BITS  operand value from pins, asynchronous
tx_busy  input  1  UART busy, high while a frame is in flight
tx_start  output  1  one-cycle pulse requesting UART to send tx_data
tx_data  output  8  byte presented to UART; stable from the tx_start cycle until busy falls
reg_a  output  BITS  latched operand A
reg_b  output  BITS  latched operand B
sum  output  BITS+1  reg_a + reg_b, zero-extended, registered
valid_a  output  1  operand A held since last transmission
valid_b  output  1  operand B held since last transmission
ctrl_busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async, rst_n=0): every output is 0; FSM=IDLE; synchronisers=1 (released); debounce counters=0; buttons disarmed-released.
- Inputs: save_a_n, save_b_n and data_in each pass through a 2-FF synchroniser.
- Debounce, per button:
  - Counter increments while the synced level differs from the accepted level and clears otherwise.
  - At DEBOUNCE the accepted level flips.
  - A 1->0 flip of the accepted level is a press event: a single-cycle pulse, exactly one per physical press.
  - Press-to-latch latency: 2 (sync) + DEBOUNCE cycles after the pin falls.
- Latching, FSM IDLE only:
  - Press A: reg_a <= synced data_in, valid_a <= 1.
  - Press B: same for reg_b / valid_b.
  - Simultaneous A and B events latch both from the same data_in sample.
  - A re-press before the other operand arrives overwrites the value; the valid flag stays 1.
  - Press events while not IDLE are discarded; they are not queued.
- FSM states: IDLE, CALC, SEND, WAIT_HI, WAIT_LO.
  - IDLE: when valid_a&valid_b are both 1 -> CALC. This check happens in the cycle after the second latch.
  - CALC: sum <= reg_a+reg_b (carry into bit BITS). Load tx_data with character 0. Set char index=0. -> SEND.
  - SEND: if tx_busy=0, pulse tx_start for 1 cycle -> WAIT_HI; else hold in SEND.
  - WAIT_HI: wait for tx_busy=1 -> WAIT_LO.
  - WAIT_LO: wait for tx_busy=0. If more characters remain, increment index, load next byte, -> SEND. Otherwise clear valid_a and valid_b -> IDLE.
- tx_start is never asserted while tx_busy=1. It is never asserted in two consecutive cycles.
- sum, reg_a and reg_b hold their values after transmission until overwritten by the next latch/CALC.
- Reset mid-transfer: immediate return to IDLE, tx_start=0, operands cleared. The UART frame is abandoned by the UART's own reset.
- Arithmetic: unsigned; the maximum sum is 2*(2^BITS-1) and always fits in BITS+1 bits; no overflow flag.

Optional Feature:
Macro ASCII_HEX_EN.
- Defined: each transmission is 3 characters, in order:
  - high hex nibble of {zero-padded sum} as ASCII ('0'-'9','A'-'F');
  - low hex nibble as ASCII;
  - 0x0A (LF).
- Not defined: each transmission is 1 raw byte: tx_data = sum zero-extended to 8 bits.

Test Plan:
- Reset: rst_n low mid-run -> all outputs 0 and ctrl_busy=0 within the same cycle; stays so for 3 cycles after release with no stimulus.
- data_in=3, press A (low 10 cycles); data_in=5, press B -> reg_a=3, reg_b=5, sum=8. One tx_start pulse, tx_data=0x08 (raw) or 0x30,0x38,0x0A (ASCII). valid flags 0 after the last busy fall.
- Bounce: save_a_n toggles every cycle for 6 cycles and then holds low (DEBOUNCE=4) -> exactly one latch, DEBOUNCE+2 cycles after the final fall; glitch shorter than DEBOUNCE -> no latch.
- Max operands: A=7, B=7 -> sum=14 (0b1110), raw tx_data=0x0E; ASCII sequence 0x30,0x45,0x0A.
- Handshake: tx_busy held high for 20 cycles when SEND is entered -> tx_start stays 0 until busy falls, then a single pulse. Presses during the transfer -> reg_a/reg_b unchanged.
- Simultaneous A and B press with data_in=2 -> reg_a=reg_b=2, sum=4, exactly one transmission.
